wb_cmd_bridge: RTL and testbench
================================

// Module: wb_cmd_bridge
// PURPOSE
//  Byte-stream command bridge: parses opcode/address/data bytes (from UART RX)
//  and acts as single-outstanding Wishbone master toward wb_memory (8/16/32-bit
//  via width signal). Returns status + read data as bytes to UART TX.
//  Sits directly upstream of the memory; host debug/loader path into the SoC.
// PARAMETERS
//  ADDR_WIDTH  6   width of o_wb_addr; equals $clog2(SIZE) of downstream memory
//  TIMEOUT     15  max cycles waiting for ack before error response (>=2)
//  (localparam ADDR_BYTES = (ADDR_WIDTH+7)/8, address bytes per command)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  reset        in   1           asynchronous, active-high reset
//  i_rx_data    in   8           incoming command byte
//  i_rx_valid   in   1           1-cycle strobe, byte valid; no backpressure
//  o_tx_data    out  8           response byte
//  o_tx_valid   out  1           1-cycle strobe, byte handed to TX
//  i_tx_busy    in   1           TX cannot accept; o_tx_valid only when low
//  o_wb_cyc     out  1           bus cycle in progress
//  o_wb_stb     out  1           request strobe
//  i_wb_stall   in   1           slave stall
//  i_wb_ack     in   1           slave ack; read data valid same cycle
//  o_wb_we      out  1           1=write
//  o_wb_width   out  2           00 byte, 01 half, 10 word
//  o_wb_addr    out  ADDR_WIDTH  byte address
//  o_wb_data    out  32          write data, little-endian, LSB = lowest addr
//  i_wb_data    in   32          read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; reset mid-transaction aborts,
//   no response sent, partial command discarded.
//  Command: OP, ADDR_BYTES addr bytes MSB first, then (write only) N data bytes
//   LSB first; N=1/2/4 per width. OP[7]=we, OP[1:0]=width, OP[6:2] must be 0.
//  Addr bits above ADDR_WIDTH dropped. Unused o_wb_data bytes driven 0.
//  States: IDLE -> ADDR -> (we ? WDATA : REQ) -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: on rx byte latch OP; illegal OP (width 11 or OP[6:2]!=0) -> RESP with
//   single 0xEE, no bus cycle.
//  ADDR/WDATA: shift bytes on each i_rx_valid; leave after last byte.
//  REQ: cyc=stb=1, we/width/addr/data stable; hold while i_wb_stall; on
//   !stall drop stb next cycle -> WAIT (cyc stays 1). Stall cycles don't count
//   toward timeout.
//  WAIT: ack -> cyc=0, capture i_wb_data masked to width -> RESP. Counter
//   reaching TIMEOUT without ack -> cyc=0 -> RESP with single 0xEE.
//   Ack outside WAIT is ignored.
//  RESP: send 0xAA, then (read) N data bytes LSB first; each byte one
//   o_tx_valid pulse in a cycle with i_tx_busy=0; next byte no earlier than
//   the following cycle. After last byte -> IDLE.
//  i_rx_valid in REQ/WAIT/RESP: byte dropped (host must wait for response).
//  Latency: ack at earliest 1 cycle after stb accepted (wb_memory: exactly 1);
//   first response byte earliest the cycle after ack.
// STRUCTURE
//  Shared include wb_cmd_defs.vh: OP bit positions, width codes (W_BYTE/W_HALF/
//   W_WORD), RSP_OK=8'hAA, RSP_ERR=8'hEE, state encodings.
//  Sub-module bridge_tx_shifter: loads {count, 32-bit word, header}, emits
//   bytes honouring i_tx_busy, signals done. Parser/bus FSM in top.
// TESTING (bench: wb_memory SIZE=64 as slave, behavioural TX with busy)
//  Write word: 82 10 78 56 34 12 -> stb once, addr=0x10, width=10,
//   data=0x12345678; TX 0xAA; mem[0x10..0x13]=78 56 34 12.
//  Read half: 01 10 -> TX AA 78 56; read byte 00 13 -> TX AA 12.
//  Stall: slave stall 3 cycles on 80 05 5A -> stb held 4 cycles, single
//   write, TX 0xAA.
//  Timeout: no-ack slave, TIMEOUT=15, cmd 02 00 -> cyc drops after 15 WAIT
//   cycles, TX single 0xEE; next cmd processed normally.
//  Illegal op 03 / 44 -> TX 0xEE, no cyc; TX busy for 5 cycles delays byte,
//   exactly one o_tx_valid per byte.
//  Reset asserted in WAIT -> all outputs 0 asynchronously, no TX; fresh
//   01 00 after reset -> AA + 2 bytes.

Source files
------------

// File: rtl/wb_cmd_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module : wb_cmd_bridge_pkg
// Brief  : Shared opcode fields, width codes, response codes and FSM states
//          for the byte-stream Wishbone command bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_cmd_bridge_pkg;

    localparam int         c_op_we   = 7;
    localparam logic [1:0] c_w_byte  = 2'b00;
    localparam logic [1:0] c_w_half  = 2'b01;
    localparam logic [1:0] c_w_word  = 2'b10;
    localparam logic [7:0] c_rsp_ok  = 8'hAA;
    localparam logic [7:0] c_rsp_err = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            c_w_byte: return 3'd1;
            c_w_half: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] mask_width(input logic [1:0] w, input logic [31:0] d);
        case (w)
            c_w_byte: return {24'h0, d[7:0]};
            c_w_half: return {16'h0, d[15:0]};
            default:  return d;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_cmd_bridge_tx_shifter.sv
//------------------------------------------------------------------------------
// Module : wb_cmd_bridge_tx_shifter
// Brief  : Emits a header byte followed by up to four word bytes (LSB first),
//          one byte per non-busy cycle; pulses o_done with the last byte.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_cmd_bridge_tx_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [2:0]  i_count,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_header,
    input  logic        i_tx_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_done
);

    logic [39:0] r_buf;
    logic [2:0]  r_left;
    logic        w_fire;

    assign w_fire     = (r_left != 3'd0) && !i_tx_busy;
    assign o_tx_valid = w_fire;
    assign o_tx_data  = w_fire ? r_buf[7:0] : 8'h00;
    assign o_done     = w_fire && (r_left == 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf  <= 40'h0;
            r_left <= 3'd0;
        end else if (i_load) begin
            r_buf  <= {i_word, i_header};
            r_left <= i_count + 3'd1;
        end else if (w_fire) begin
            r_buf  <= {8'h00, r_buf[39:8]};
            r_left <= r_left - 3'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_cmd_bridge.sv
//------------------------------------------------------------------------------
// Module : wb_cmd_bridge
// Brief  : Parses opcode/address/data bytes from a UART stream, runs one
//          Wishbone transfer at a time and returns status plus read data.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_cmd_bridge
    import wb_cmd_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_busy,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    output logic                  o_wb_we,
    output logic [1:0]            o_wb_width,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    input  logic [31:0]           i_wb_data
);

    localparam int         c_addr_bytes = (ADDR_WIDTH + 7) / 8;
    localparam logic [2:0] c_addr_last  = 3'(c_addr_bytes - 1);
    localparam int         c_tw         = $clog2(TIMEOUT + 1);

    state_t                r_state, w_next;
    logic                  r_we;
    logic [1:0]            r_width;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_cnt;
    logic [c_tw-1:0]       r_timer;

    logic        w_op_legal;
    logic [2:0]  w_nbytes;
    logic        w_load;
    logic [7:0]  w_load_hdr;
    logic [2:0]  w_load_cnt;
    logic [31:0] w_load_word;
    logic        w_tx_done;

    assign w_op_legal = (i_rx_data[6:2] == 5'd0) && (i_rx_data[1:0] != 2'b11);
    assign w_nbytes   = width_bytes(r_width);

    assign o_wb_cyc   = (r_state == S_REQ) || (r_state == S_WAIT);
    assign o_wb_stb   = (r_state == S_REQ);
    assign o_wb_we    = r_we;
    assign o_wb_width = r_width;
    assign o_wb_addr  = r_addr;
    assign o_wb_data  = r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_hdr  = c_rsp_ok;
        w_load_cnt  = 3'd0;
        w_load_word = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (w_op_legal) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next     = S_RESP;
                        w_load     = 1'b1;
                        w_load_hdr = c_rsp_err;
                    end
                end
            end
            S_ADDR: begin
                if (i_rx_valid && (r_cnt == c_addr_last)) begin
                    w_next = r_we ? S_WDATA : S_REQ;
                end
            end
            S_WDATA: begin
                if (i_rx_valid && (r_cnt == (w_nbytes - 3'd1))) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!i_wb_stall) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_wb_ack) begin
                    w_next      = S_RESP;
                    w_load      = 1'b1;
                    w_load_cnt  = r_we ? 3'd0 : w_nbytes;
                    w_load_word = mask_width(r_width, i_wb_data);
                end else if (r_timer == c_tw'(TIMEOUT - 1)) begin
                    w_next     = S_RESP;
                    w_load     = 1'b1;
                    w_load_hdr = c_rsp_err;
                end
            end
            S_RESP: begin
                if (w_tx_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command field capture; r_cnt indexes address bytes, then data bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_width <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_cnt   <= 3'd0;
            r_timer <= '0;
        end else begin
            r_timer <= (r_state == S_WAIT) ? r_timer + 1'b1 : '0;
            if (i_rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        r_we    <= i_rx_data[c_op_we];
                        r_width <= i_rx_data[1:0];
                        r_wdata <= 32'h0;
                        r_cnt   <= 3'd0;
                    end
                    S_ADDR: begin
                        r_addr <= ADDR_WIDTH'({r_addr, i_rx_data});
                        r_cnt  <= (r_cnt == c_addr_last) ? 3'd0 : r_cnt + 3'd1;
                    end
                    S_WDATA: begin
                        r_wdata[8*r_cnt[1:0] +: 8] <= i_rx_data;
                        r_cnt                      <= r_cnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    wb_cmd_bridge_tx_shifter u_tx (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_count    (w_load_cnt),
        .i_word     (w_load_word),
        .i_header   (w_load_hdr),
        .i_tx_busy  (i_tx_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (w_tx_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_wb_cmd_bridge
// Brief  : Directed bench for wb_cmd_bridge with a behavioural memory slave,
//          a busy-capable TX sink and a command-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_cmd_bridge;

    localparam int AW = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy;
    logic          cyc, stb, stall, ack, we;
    logic [1:0]    width;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;

    wb_cmd_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_busy  (tx_busy),
        .o_wb_cyc   (cyc),
        .o_wb_stb   (stb),
        .i_wb_stall (stall),
        .i_wb_ack   (ack),
        .o_wb_we    (we),
        .o_wb_width (width),
        .o_wb_addr  (addr),
        .o_wb_data  (wdata),
        .i_wb_data  (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [1:0]  w;
        logic [5:0]  a;
        logic [31:0] d;
    } req_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  smem [64];
    logic [7:0]  mmem [64];
    logic [7:0]  exp_tx [$];
    logic [7:0]  tx_log [$];
    req_t        exp_req [$];
    int          stall_left = 0;
    bit          noack = 1'b0;
    bit          ack_pending = 1'b0;
    logic [31:0] pend_data = 32'h0;
    int          stb_cycles, wait_cycles, cyc_cycles, acc_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave, TX sink and per-cycle comparison against the model queues.
    always @(negedge clk) begin
        if (reset) begin
            ack         = 1'b0;
            stall       = 1'b0;
            rdata       = 32'h0;
            ack_pending = 1'b0;
        end else begin
            ack         = ack_pending;
            rdata       = ack_pending ? pend_data : 32'h0;
            ack_pending = 1'b0;
            stall       = stb && (stall_left > 0);
            if (stall) stall_left--;
            if (stb) stb_cycles++;
            if (cyc) cyc_cycles++;
            if (cyc && !stb) wait_cycles++;
            if (stb) check("stb_implies_cyc", {31'h0, cyc}, 32'h1);
            if (stb && !stall) begin
                acc_count++;
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected: got request addr %h, expected none", addr);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("bus_we",    {31'h0, we},    {31'h0, r.we});
                    check("bus_width", {30'h0, width}, {30'h0, r.w});
                    check("bus_addr",  {26'h0, addr},  {26'h0, r.a});
                    if (r.we) check("bus_wdata", wdata, r.d);
                end
                for (int i = 0; i < (1 << width); i++) begin
                    if (we) smem[(int'(addr) + i) % 64] = wdata[8*i +: 8];
                end
                for (int i = 0; i < 4; i++) pend_data[8*i +: 8] = smem[(int'(addr) + i) % 64];
                ack_pending = !noack;
            end
            if (tx_valid) begin
                check("tx_while_busy", {31'h0, tx_busy}, 32'h0);
                tx_log.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
            end
        end
    end

    task automatic model_cmd(input int len, input logic [7:0] b [6]);
        logic [7:0] op;
        req_t       r;
        int         n;
        op = b[0];
        if (op[1:0] == 2'b11 || op[6:2] != 5'd0) begin
            exp_tx.push_back(8'hEE);
            return;
        end
        n    = 1 << op[1:0];
        r.we = op[7];
        r.w  = op[1:0];
        r.a  = b[1][5:0];
        r.d  = 32'h0;
        if (r.we) for (int i = 0; i < n && 2 + i < len; i++) r.d[8*i +: 8] = b[2+i];
        exp_req.push_back(r);
        if (noack) begin
            exp_tx.push_back(8'hEE);
        end else begin
            exp_tx.push_back(8'hAA);
            for (int i = 0; i < n; i++) begin
                if (r.we) mmem[(int'(r.a) + i) % 64] = r.d[8*i +: 8];
                else      exp_tx.push_back(mmem[(int'(r.a) + i) % 64]);
            end
        end
    endtask

    task automatic send_bytes(input int len, input logic [7:0] b [6]);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rx_data  = b[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_cmd(input int len, input logic [7:0] b0, b1, b2, b3, b4, b5,
                          input int busy_pre, input bit toggle);
        logic [7:0] b [6];
        int         k;
        b = '{b0, b1, b2, b3, b4, b5};
        tx_log.delete();
        stb_cycles = 0; wait_cycles = 0; cyc_cycles = 0; acc_count = 0;
        model_cmd(len, b);
        if (busy_pre > 0) tx_busy = 1'b1;
        send_bytes(len, b);
        if (busy_pre > 0) begin
            repeat (busy_pre) @(posedge clk);
            #1;
            check("busy_holds_tx", tx_log.size(), 0);
            tx_busy = 1'b0;
        end
        k = 0;
        while ((exp_tx.size() != 0 || cyc) && k < 300) begin
            @(posedge clk); #1;
            if (toggle) tx_busy = (k % 3 == 1);
            k++;
        end
        tx_busy = 1'b0;
        if (k >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: got %0d bytes pending, expected 0", exp_tx.size());
            exp_tx.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        check("req_consumed", exp_req.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        check({tag, "_tx_data"},  {24'h0, tx_data},  32'h0);
        check({tag, "_cyc"},      {31'h0, cyc},      32'h0);
        check({tag, "_stb"},      {31'h0, stb},      32'h0);
        check({tag, "_we"},       {31'h0, we},       32'h0);
        check({tag, "_width"},    {30'h0, width},    32'h0);
        check({tag, "_addr"},     {26'h0, addr},     32'h0);
        check({tag, "_wdata"},    wdata,             32'h0);
    endtask

    initial begin
        logic [7:0] b [6];
        int         k;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            smem[i] = 8'(i * 7 + 3);
            mmem[i] = 8'(i * 7 + 3);
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Write word, then literal checks that pin the model.
        do_cmd(6, 8'h82, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 0, 1'b0);
        check("ww_mem10", {24'h0, smem[16]}, 32'h78);
        check("ww_mem13", {24'h0, smem[19]}, 32'h12);
        check("ww_tx_len", tx_log.size(), 1);
        check("ww_tx0", {24'h0, tx_log[0]}, 32'hAA);
        check("ww_stb_cycles", stb_cycles, 1);
        check("ww_wait_cycles", wait_cycles, 1);

        do_cmd(2, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("rh_tx_len", tx_log.size(), 3);
        check("rh_tx1", {24'h0, tx_log[1]}, 32'h78);
        check("rh_tx2", {24'h0, tx_log[2]}, 32'h56);

        do_cmd(2, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("rb_tx_len", tx_log.size(), 2);
        check("rb_tx1", {24'h0, tx_log[1]}, 32'h12);

        // Stalled byte write.
        stall_left = 3;
        do_cmd(3, 8'h80, 8'h05, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("st_stb_cycles", stb_cycles, 4);
        check("st_acc_count", acc_count, 1);
        check("st_mem05", {24'h0, smem[5]}, 32'h5A);
        check("st_tx_len", tx_log.size(), 1);

        // Read word with intermittent TX busy.
        do_cmd(2, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1);
        check("rw_tx_len", tx_log.size(), 5);
        check("rw_tx4", {24'h0, tx_log[4]}, 32'h12);

        // Timeout, then a normal command.
        noack = 1'b1;
        do_cmd(2, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("to_wait_cycles", wait_cycles, TO);
        check("to_tx_len", tx_log.size(), 1);
        check("to_tx0", {24'h0, tx_log[0]}, 32'hEE);
        noack = 1'b0;
        do_cmd(2, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("after_to_tx1", {24'h0, tx_log[1]}, 32'h5A);

        // Illegal opcodes, second one with TX held busy.
        do_cmd(1, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("ill03_cyc", cyc_cycles, 0);
        check("ill03_tx0", {24'h0, tx_log[0]}, 32'hEE);
        do_cmd(1, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5, 1'b0);
        check("ill44_cyc", cyc_cycles, 0);
        check("ill44_tx_len", tx_log.size(), 1);

        // Reset while waiting for an ack.
        noack = 1'b1;
        tx_log.delete();
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_cmd(2, b);
        send_bytes(2, b);
        k = 0;
        while (!(cyc && !stb) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_reached_wait", {31'h0, cyc && !stb}, 32'h1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        exp_tx.delete();
        exp_req.delete();
        noack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_tx", tx_log.size(), 0);
        do_cmd(2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("post_rst_len", tx_log.size(), 3);
        check("post_rst_tx0", {24'h0, tx_log[0]}, 32'hAA);
        check("post_rst_tx1", {24'h0, tx_log[1]}, 32'h03);
        check("post_rst_tx2", {24'h0, tx_log[2]}, 32'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
